// File: rtl/counter_scheduler_if.sv
// Purpose : Bundles the requester handshake and the shared-counter control
//           pins used by counter_scheduler.
// Signals : req       - level request per requester (held until ack/timeout)
//           grant     - one-hot owner of the counter, 0 when idle
//           ack       - one-cycle pulse to the owner: run completed
//           timeout   - one-cycle pulse to the owner: run aborted by watchdog
//           busy      - high from grant until the scheduler is idle again
//           ctr_start - one-cycle start pulse to the counter
//           ctr_clear - one-cycle active-high clear to the counter on abort
//           ctr_done  - one-cycle done pulse from the counter
// Modports: master - requesters/counter side; slave - the scheduler.
// NUM_REQ must match the NUM_REQ of the counter_scheduler it connects to.
interface counter_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] ack;
    logic [NUM_REQ-1:0] timeout;
    logic               busy;
    logic               ctr_start;
    logic               ctr_clear;
    logic               ctr_done;

    modport master (
        output req, ctr_done,
        input  grant, ack, timeout, busy, ctr_start, ctr_clear
    );

    modport slave (
        input  req, ctr_done,
        output grant, ack, timeout, busy, ctr_start, ctr_clear
    );
endinterface

// File: rtl/counter_scheduler.sv
// Purpose : Shares one counter between NUM_REQ requesters with round-robin
//           arbitration. Grants one requester, pulses the counter start,
//           waits for the counter done pulse and returns a one-cycle ack to
//           the owner. A watchdog aborts a run that overstays TIMEOUT_CYCLES,
//           pulsing timeout to the owner and ctr_clear to the counter.
// Ports   : clock   - rising-edge clock
//           reset_n - asynchronous active-low reset
//           bus     - counter_scheduler_if.slave (req/ctr_done in;
//                     grant/ack/timeout/busy/ctr_start/ctr_clear out)
// All outputs are registered.
module counter_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 300
) (
    input  logic                  clock,
    input  logic                  reset_n,
    counter_scheduler_if.slave    bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        RELEASE
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   idx;
    logic [WD_W-1:0]    wd;

    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] ack_q;
    logic [NUM_REQ-1:0] timeout_q;
    logic               busy_q;
    logic               start_q;
    logic               clear_q;

    // Round-robin pick: first set req bit at or above ptr, wrapping.
    logic [IDX_W-1:0]   pick;
    logic               found;
    int unsigned        pos;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [NUM_REQ-1:0] idx_onehot;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        pos   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = 32'(ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (!found && bus.req[pos[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = pos[IDX_W-1:0];
            end
        end
    end

    assign pick_onehot = NUM_REQ'(1) << pick;
    assign idx_onehot  = NUM_REQ'(1) << idx;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= '0;
            idx       <= '0;
            wd        <= '0;
            grant_q   <= '0;
            ack_q     <= '0;
            timeout_q <= '0;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
            clear_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_q <= pick_onehot;
                        idx     <= pick;
                        busy_q  <= 1'b1;
                        start_q <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    start_q <= 1'b0;
                    wd      <= '0;
                    state   <= RUN;
                end
                RUN: begin
                    wd <= wd + 1'b1;
                    // grant drops together with the result pulse, so it is
                    // already low in RELEASE and stays low through the next
                    // IDLE cycle; ack/timeout still target the stored idx.
                    if (bus.ctr_done) begin
                        ack_q   <= idx_onehot;
                        grant_q <= '0;
                        state   <= RELEASE;
                    end else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_q <= idx_onehot;
                        clear_q   <= 1'b1;
                        grant_q   <= '0;
                        state     <= RELEASE;
                    end
                end
                RELEASE: begin
                    ack_q     <= '0;
                    timeout_q <= '0;
                    clear_q   <= 1'b0;
                    grant_q   <= '0;
                    busy_q    <= 1'b0;
                    ptr       <= (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.ack       = ack_q;
    assign bus.timeout   = timeout_q;
    assign bus.busy      = busy_q;
    assign bus.ctr_start = start_q;
    assign bus.ctr_clear = clear_q;

endmodule

// File: tb/tb_counter_scheduler.sv
// Bench for counter_scheduler: the stimulus process plays the requesters and
// the counter, predicts each grant and each ack/timeout from a round-robin
// reference model and queues the expectations; a monitor pops and compares
// them whenever the DUT raises a grant or a result pulse.
module tb_counter_scheduler;
    localparam int N = 4;
    localparam int T = 8;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned ptr_m = 0;

    typedef struct {
        logic [N-1:0] g;
        int unsigned  cyc;
    } exp_grant_t;

    typedef struct {
        logic [N-1:0] ack;
        logic [N-1:0] to;
        logic         clr;
        int unsigned  cyc;
    } exp_done_t;

    exp_grant_t gq[$];
    exp_done_t  dq[$];

    counter_scheduler_if #(.NUM_REQ(N)) bus ();

    counter_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference arbitration: rotate the request so ptr sits at bit 0, take
    // the lowest set bit, rotate back.
    function automatic int unsigned model_pick(input logic [N-1:0] r, input int unsigned p);
        logic [2*N-1:0] dbl;
        logic [N-1:0]   rot;
        dbl = {r, r};
        rot = N'(dbl >> p);
        for (int i = 0; i < N; i++) begin
            if (rot[i]) return (p + i) % N;
        end
        return 0;
    endfunction

    function automatic logic [N-1:0] oh(input int unsigned i);
        logic [N-1:0] one;
        one = 1;
        return one << i;
    endfunction

    // Monitor
    logic [N-1:0] prev_grant = '0;
    logic         prev_start = 1'b0;
    int unsigned  gap = 100;

    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.grant != '0 && prev_grant == '0) begin
                checks++;
                if (gq.size() == 0) begin
                    errors++;
                    $display("FAIL grant_unexpected got=%b cyc=%0d", bus.grant, cyc);
                end else begin
                    exp_grant_t e;
                    e = gq.pop_front();
                    if (bus.grant !== e.g || cyc != e.cyc || bus.ctr_start !== 1'b1 ||
                        bus.busy !== 1'b1 || gap < 2) begin
                        errors++;
                        $display("FAIL grant got=%b@%0d start=%b busy=%b gap=%0d exp=%b@%0d start=1 busy=1 gap>=2",
                                 bus.grant, cyc, bus.ctr_start, bus.busy, gap, e.g, e.cyc);
                    end
                end
            end
            if (bus.grant != '0) gap = 0;
            else gap++;

            if (bus.ack != '0 || bus.timeout != '0 || bus.ctr_clear) begin
                checks++;
                if (dq.size() == 0) begin
                    errors++;
                    $display("FAIL result_unexpected ack=%b timeout=%b clr=%b cyc=%0d",
                             bus.ack, bus.timeout, bus.ctr_clear, cyc);
                end else begin
                    exp_done_t d;
                    d = dq.pop_front();
                    if (bus.ack !== d.ack || bus.timeout !== d.to || bus.ctr_clear !== d.clr || cyc != d.cyc) begin
                        errors++;
                        $display("FAIL result got ack=%b to=%b clr=%b @%0d exp ack=%b to=%b clr=%b @%0d",
                                 bus.ack, bus.timeout, bus.ctr_clear, cyc, d.ack, d.to, d.clr, d.cyc);
                    end
                end
            end

            if (bus.ctr_start && prev_start) begin
                checks++;
                errors++;
                $display("FAIL start_pulse got=2+ cycles exp=1 cycle @%0d", cyc);
            end
        end
        prev_grant = bus.grant;
        prev_start = bus.ctr_start;
    end

    // Must be entered at a negedge with the DUT idle. k=1..T: counter done
    // in RUN cycle k; k=0: counter never answers. Returns at the negedge of
    // the next IDLE cycle with req = r_after.
    task automatic run_txn(input logic [N-1:0] r, input int unsigned k,
                           input logic [N-1:0] r_after, input bit spurious);
        int unsigned w, n, c0, kk;
        if (spurious) begin
            bus.req = '0;
            bus.ctr_done = 1'b1;
            @(negedge clock);
            bus.ctr_done = 1'b0;
        end
        bus.req = r;
        w = model_pick(r, ptr_m);
        gq.push_back('{g: oh(w), cyc: cyc + 1});
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!bus.ctr_start && n < 6);
        if (!bus.ctr_start) begin
            checks++;
            errors++;
            $display("FAIL start_wait got=no ctr_start exp=ctr_start within 6 cycles");
            return;
        end
        c0 = cyc;
        bus.req = r_after;
        kk = (k == 0) ? T : k;
        if (k == 0) dq.push_back('{ack: '0, to: oh(w), clr: 1'b1, cyc: c0 + kk + 1});
        else        dq.push_back('{ack: oh(w), to: '0, clr: 1'b0, cyc: c0 + kk + 1});
        repeat (kk) @(negedge clock);
        if (k != 0) bus.ctr_done = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            bus.ctr_done = 1'b0;
            n++;
        end while (bus.busy && n < 6);
        if (bus.busy) begin
            checks++;
            errors++;
            $display("FAIL idle_wait got=busy exp=idle within 6 cycles");
        end
        ptr_m = (w + 1) % N;
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (bus.grant !== '0 || bus.ack !== '0 || bus.timeout !== '0 ||
            bus.busy !== 1'b0 || bus.ctr_start !== 1'b0 || bus.ctr_clear !== 1'b0) begin
            errors++;
            $display("FAIL %s got grant=%b ack=%b to=%b busy=%b start=%b clr=%b exp all 0",
                     name, bus.grant, bus.ack, bus.timeout, bus.busy, bus.ctr_start, bus.ctr_clear);
        end
    endtask

    initial begin
        logic [N-1:0] r, ra;
        int unsigned  k;
        bus.req = '0;
        bus.ctr_done = 1'b0;
        repeat (3) @(negedge clock);
        check_zero("reset_state");
        reset_n = 1'b1;
        @(negedge clock);

        // Single requester, done in RUN cycle 5
        run_txn(4'b0100, 5, 4'b0000, 1'b0);
        run_txn(4'b1000, 2, 4'b0000, 1'b0);        // brings ptr back to 0
        // All requesting: strict rotation
        for (int i = 0; i < 5; i++) run_txn(4'b1111, 1 + i, 4'b1111, 1'b0);
        // ptr=2 with 1010: 1000 then wrap to 0010
        run_txn(4'b0010, 3, 4'b0000, 1'b0);
        run_txn(4'b1010, 4, 4'b1010, 1'b0);
        run_txn(4'b1010, 4, 4'b0000, 1'b1);
        // Watchdog abort, then the next requester
        run_txn(4'b0101, 0, 4'b0101, 1'b0);
        run_txn(4'b0101, 3, 4'b0000, 1'b0);
        // Done on the watchdog terminal cycle: ack wins
        run_txn(4'b0001, T, 4'b0000, 1'b0);
        run_txn(4'b0010, 1, 4'b0000, 1'b0);

        // Reset in the middle of a run
        bus.req = 4'b0100;
        gq.push_back('{g: oh(model_pick(4'b0100, ptr_m)), cyc: cyc + 1});
        repeat (4) @(negedge clock);
        #2 reset_n = 1'b0;
        #1 check_zero("async_reset");
        bus.req = '0;
        ptr_m = 0;
        @(negedge clock);
        check_zero("reset_hold");
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        run_txn(4'b1001, 3, 4'b0000, 1'b0);

        // Randomised traffic; the mid-run request becomes the next request
        r = 4'(($urandom % 15) + 1);
        for (int i = 0; i < 40; i++) begin
            k  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, T);
            ra = 4'($urandom_range(0, 15));
            run_txn(r, k, ra, ($urandom_range(0, 4) == 0));
            r = (ra != '0) ? ra : 4'(($urandom % 15) + 1);
        end
        bus.req = '0;
        repeat (3) @(negedge clock);

        checks++;
        if (gq.size() != 0 || dq.size() != 0) begin
            errors++;
            $display("FAIL drain got grants_left=%0d results_left=%0d exp 0/0", gq.size(), dq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout got=still running exp=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end
endmodule
